// File: rtl/rv_m_pkg.sv
// Shared definitions for the RV M-extension iterative multiply/divide unit:
// funct3 encodings, FSM state type and a most-negative-value helper.
package rv_m_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int MAX_XLEN = 64;

    // Two's-complement most-negative value for an xlen-bit word, zero-extended.
    function automatic logic [MAX_XLEN-1:0] most_neg(input int xlen);
        return {{(MAX_XLEN-1){1'b0}}, 1'b1} << (xlen - 1);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/result bus between the EX stage (master) and the multiply/divide unit (slave).
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic [4:0]      rd_addr_i;
    logic            flush_i;
    logic            busy_o;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_addr_o;

    modport master (
        output start_i, op_i, rs1_i, rs2_i, rd_addr_i, flush_i,
        input  busy_o, stall_o, done_o, result_o, rd_addr_o
    );

    modport slave (
        input  start_i, op_i, rs1_i, rs2_i, rd_addr_i, flush_i,
        output busy_o, stall_o, done_o, result_o, rd_addr_o
    );
endinterface

// File: rtl/muldiv_step.sv
// One combinational radix-2 step: shift-add for multiply (multiplier in low half,
// product accumulating from the top) or restoring shift-subtract for divide.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div_i,
    input  logic [XLEN-1:0]   opd_i,
    input  logic [2*XLEN-1:0] acc_i,
    output logic [2*XLEN-1:0] acc_o
);
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff_lo;
    logic            take;

    assign sum     = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opd_i} : '0);
    // Partial remainder is always below the divisor, so one extra bit holds 2r+1.
    assign shifted = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
    assign take    = shifted >= {1'b0, opd_i};
    assign diff_lo = shifted[XLEN-1:0] - opd_i;

    always_comb begin
        acc_o = {sum, acc_i[XLEN-1:1]};
        if (is_div_i) begin
            if (take) begin
                acc_o = {diff_lo, acc_i[XLEN-2:0], 1'b1};
            end else begin
                acc_o = {shifted[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension execute unit: sign-magnitude front end, BITS_PER_CYCLE
// radix-2 steps per CALC cycle, sign fix-up, and a one-cycle done pulse.
module muldiv_unit
    import rv_m_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    muldiv_unit_if.slave bus
);
    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]       LAST    = CW'(N - 1);
    localparam logic [MAX_XLEN-1:0] MN_FULL = most_neg(XLEN);
    localparam logic [XLEN-1:0]     MOST_NEG = MN_FULL[XLEN-1:0];

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opd_q;
    logic [XLEN-1:0]   result_q;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic              neg_q;
    logic              special_q;
    logic              done_q;

    logic            in_div, in_rem, sign_a, sign_b, neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b, special_res;
    logic            div_zero, div_ovf, special;

    assign in_div = bus.op_i[2];
    assign in_rem = bus.op_i[2] & bus.op_i[1];
    assign sign_a = (bus.op_i == F3_MULH) | (bus.op_i == F3_MULHSU) |
                    (bus.op_i == F3_DIV)  | (bus.op_i == F3_REM);
    assign sign_b = (bus.op_i == F3_MULH) | (bus.op_i == F3_DIV) | (bus.op_i == F3_REM);
    assign neg_a  = sign_a & bus.rs1_i[XLEN-1];
    assign neg_b  = sign_b & bus.rs2_i[XLEN-1];
    assign mag_a  = neg_a ? -bus.rs1_i : bus.rs1_i;
    assign mag_b  = neg_b ? -bus.rs2_i : bus.rs2_i;

    assign div_zero = in_div & (bus.rs2_i == '0);
    assign div_ovf  = ((bus.op_i == F3_DIV) | (bus.op_i == F3_REM)) &
                      (bus.rs1_i == MOST_NEG) & (bus.rs2_i == '1);
    assign special  = div_zero | div_ovf;

    always_comb begin
        special_res = in_rem ? '0 : MOST_NEG;
        if (div_zero) begin
            special_res = in_rem ? bus.rs1_i : '1;
        end
    end

    logic [2*XLEN-1:0] chain [BITS_PER_CYCLE+1];
    assign chain[0] = acc_q;

    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
            muldiv_step #(.XLEN(XLEN)) u_step (
                .is_div_i (op_q[2]),
                .opd_i    (opd_q),
                .acc_i    (chain[gi]),
                .acc_o    (chain[gi+1])
            );
        end
    endgenerate

    // Divide leaves remainder in the high half and quotient in the low half.
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   div_sel, fix_res;

    always_comb begin
        prod    = neg_q ? -acc_q : acc_q;
        div_sel = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        fix_res = '0;
        if (op_q[2]) begin
            fix_res = neg_q ? -div_sel : div_sel;
        end else if (op_q == F3_MUL) begin
            fix_res = prod[XLEN-1:0];
        end else begin
            fix_res = prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opd_q     <= '0;
            result_q  <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (bus.flush_i && state_q != ST_IDLE) begin
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start_i && !bus.flush_i) begin
                        op_q      <= bus.op_i;
                        rd_q      <= bus.rd_addr_i;
                        cnt_q     <= '0;
                        special_q <= special;
                        result_q  <= special_res;
                        neg_q     <= in_rem ? neg_a : (neg_a ^ neg_b);
                        if (in_div) begin
                            acc_q <= {{XLEN{1'b0}}, mag_a};
                            opd_q <= mag_b;
                        end else begin
                            acc_q <= {{XLEN{1'b0}}, mag_b};
                            opd_q <= mag_a;
                        end
                        state_q <= special ? ST_FIX : ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_q <= chain[BITS_PER_CYCLE];
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (!special_q) begin
                        result_q <= fix_res;
                    end
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                default: begin
                    done_q   <= 1'b0;
                    result_q <= '0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    // A flush arriving in DONE must still kill the pulse already registered.
    assign bus.busy_o    = (state_q != ST_IDLE);
    assign bus.stall_o   = bus.busy_o | (bus.start_i & (state_q == ST_IDLE));
    assign bus.done_o    = done_q & ~bus.flush_i;
    assign bus.result_o  = bus.done_o ? result_q : '0;
    assign bus.rd_addr_o = rd_q;
endmodule
